// File: rtl/prf_free_list.sv
// Physical-register free list: hands PRF indices to two rename slots and reclaims retired mappings.
// Latency: grant/index combinational from registered state; pointers and count update at the next clk edge.
// Backpressure: a slot that cannot be served gets no grant (slot1 never bypasses a denied slot0); flush/reset force zero grants.
module prf_free_list #(
    parameter int PRF_IDX  = 6,
    parameter int PRF_SZ   = 64,
    parameter int ARF_SZ   = 32,
    parameter int FL_DEPTH = PRF_SZ - ARF_SZ
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [1:0]             alloc_req,
    output logic [1:0]             alloc_gnt,
    output logic [2*PRF_IDX-1:0]   alloc_idx,
    input  logic [1:0]             commit,
    input  logic [2*PRF_IDX-1:0]   free_idx,
    output logic [PRF_IDX-1:0]     free_cnt,
    output logic                   empty
);
    localparam int PW = $clog2(FL_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Circular buffer of free indices plus speculative (head), retire (rhead) and write (tail) pointers.
    // tail and rhead always advance together, so a commit overwrites the slot its allocation came from.
    logic [PRF_IDX-1:0] fl_q [FL_DEPTH];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      rhead_q, rhead_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [PRF_IDX-1:0] free_cnt_q, free_cnt_d;

    logic [1:0]         gnt;
    logic [1:0]         n_alloc;
    logic [1:0]         n_commit;
    logic [PW-1:0]      wr_addr1;

    // In-order grant: slot1 only proceeds if slot0 is idle or also granted; nothing granted during flush/reset.
    always_comb begin
        logic g0;
        gnt       = 2'b00;
        alloc_idx = '0;
        g0        = 1'b0;
        if (!reset && !flush) begin
            g0     = alloc_req[0] && (free_cnt_q != '0);
            gnt[0] = g0;
            gnt[1] = alloc_req[1] &&
                     (alloc_req[0] ? (g0 && (free_cnt_q >= PRF_IDX'(2)))
                                   : (free_cnt_q != '0));
        end
        if (gnt[0]) begin
            alloc_idx[PRF_IDX-1:0] = fl_q[head_q];
        end
        if (gnt[1]) begin
            alloc_idx[2*PRF_IDX-1:PRF_IDX] = gnt[0] ? fl_q[head_q + PTR_ONE] : fl_q[head_q];
        end
    end

    assign alloc_gnt = gnt;
    assign free_cnt  = free_cnt_q;
    assign empty     = (free_cnt_q == '0);

    // Next-state pointers and count; a flush rewinds head to the retire point after this cycle's commits.
    always_comb begin
        n_alloc    = {1'b0, gnt[0]} + {1'b0, gnt[1]};
        n_commit   = {1'b0, commit[0]} + {1'b0, commit[1]};
        wr_addr1   = tail_q + PW'(commit[0]);
        tail_d     = tail_q + PW'(n_commit);
        rhead_d    = rhead_q + PW'(n_commit);
        head_d     = head_q + PW'(n_alloc);
        free_cnt_d = free_cnt_q - PRF_IDX'(n_alloc) + PRF_IDX'(n_commit);
        if (flush) begin
            head_d     = rhead_d;
            free_cnt_d = PRF_IDX'(FL_DEPTH);
        end
    end

    // State update: reset reloads the buffer with the initially unmapped registers and drops any concurrent commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                fl_q[k] <= PRF_IDX'(ARF_SZ + k);
            end
            head_q     <= '0;
            rhead_q    <= '0;
            tail_q     <= '0;
            free_cnt_q <= PRF_IDX'(FL_DEPTH);
        end else begin
            if (commit[0]) begin
                fl_q[tail_q] <= free_idx[PRF_IDX-1:0];
            end
            if (commit[1]) begin
                fl_q[wr_addr1] <= free_idx[2*PRF_IDX-1:PRF_IDX];
            end
            head_q     <= head_d;
            rhead_q    <= rhead_d;
            tail_q     <= tail_d;
            free_cnt_q <= free_cnt_d;
        end
    end
endmodule

// File: tb/tb_prf_free_list.sv
// Directed bench for prf_free_list: a cycle-by-cycle vector table plus a short flush-only sequence.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Each vector's expected free_cnt is the registered value seen before that cycle's edge.
module tb_prf_free_list;
    logic        clk;
    logic        reset;
    logic        flush;
    logic [1:0]  alloc_req;
    logic [1:0]  alloc_gnt;
    logic [11:0] alloc_idx;
    logic [1:0]  commit;
    logic [11:0] free_idx;
    logic [5:0]  free_cnt;
    logic        empty;

    prf_free_list dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .alloc_req (alloc_req),
        .alloc_gnt (alloc_gnt),
        .alloc_idx (alloc_idx),
        .commit    (commit),
        .free_idx  (free_idx),
        .free_cnt  (free_cnt),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       fl;
        logic [1:0] req;
        logic [1:0] cm;
        int         f0;
        int         f1;
        logic [1:0] gnt;
        int         i0;
        int         i1;
        int         cnt;
    } vec_t;

    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst, input logic fl, input logic [1:0] req, input logic [1:0] cm,
                       input int f0, input int f1, input logic [1:0] gnt, input int i0, input int i1,
                       input int cnt);
        vec_t v;
        v.rst = rst; v.fl = fl; v.req = req; v.cm = cm; v.f0 = f0; v.f1 = f1;
        v.gnt = gnt; v.i0 = i0; v.i1 = i1; v.cnt = cnt;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic [1:0] req, input logic [1:0] cm,
                         input int f0, input int f1);
        reset     = rst;
        flush     = fl;
        alloc_req = req;
        commit    = cm;
        free_idx  = {f1[5:0], f0[5:0]};
    endtask

    task automatic check_outs(input string tag, input logic [1:0] gnt, input int i0, input int i1,
                              input int cnt);
        chk({tag, " gnt"},   int'(alloc_gnt), int'(gnt));
        chk({tag, " idx0"},  int'(alloc_idx[5:0]), i0);
        chk({tag, " idx1"},  int'(alloc_idx[11:6]), i1);
        chk({tag, " cnt"},   int'(free_cnt), cnt);
        chk({tag, " empty"}, int'(empty), (cnt == 0) ? 1 : 0);
    endtask

    initial begin
        // Fresh list: first pair is P32,P33.
        add(0,0,2'b00,2'b00, 0,0, 2'b00, 0, 0, 32);
        add(0,0,2'b11,2'b00, 0,0, 2'b11,32,33, 32);
        add(0,0,2'b00,2'b00, 0,0, 2'b00, 0, 0, 30);
        // Drain the remaining 30 entries two at a time, ending with 62,63.
        for (int i = 0; i < 15; i++)
            add(0,0,2'b11,2'b00, 0,0, 2'b11, 34+2*i, 35+2*i, 30-2*i);
        add(0,0,2'b11,2'b00, 0,0, 2'b00, 0, 0, 0);
        // Commits while empty are not visible until the next cycle.
        add(0,0,2'b11,2'b11, 5,7, 2'b00, 0, 0, 0);
        add(0,0,2'b11,2'b00, 0,0, 2'b11, 5, 7, 2);
        // One entry available: a pair request gets slot0 only.
        add(0,0,2'b00,2'b01, 9,0, 2'b00, 0, 0, 0);
        add(0,0,2'b11,2'b00, 0,0, 2'b01, 9, 0, 1);
        // One entry available, slot1 alone: it takes the head entry.
        add(0,0,2'b00,2'b10, 0,11, 2'b00, 0, 0, 0);
        add(0,0,2'b10,2'b00, 0,0, 2'b10, 0,11, 1);
        add(0,0,2'b00,2'b00, 0,0, 2'b00, 0, 0, 0);
        // Reset during traffic: no grants, then the post-reset pair.
        add(1,0,2'b11,2'b11, 1,2, 2'b00, 0, 0, 0);
        add(0,0,2'b11,2'b00, 0,0, 2'b11,32,33, 32);
        add(0,0,2'b01,2'b00, 0,0, 2'b01,34, 0, 30);
        // Flush with a same-cycle commit of P3: head rewinds to just past the committed slot.
        add(0,1,2'b11,2'b01, 3,0, 2'b00, 0, 0, 29);
        add(0,0,2'b11,2'b00, 0,0, 2'b11,33,34, 32);
        for (int j = 0; j < 14; j++)
            add(0,0,2'b11,2'b00, 0,0, 2'b11, 35+2*j, 36+2*j, 30-2*j);
        // P3 comes back right after P63.
        add(0,0,2'b11,2'b00, 0,0, 2'b11,63, 3, 2);
        add(0,0,2'b11,2'b00, 0,0, 2'b00, 0, 0, 0);

        drive(1,0,2'b00,2'b00,0,0);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < vt.size(); k++) begin
            drive(vt[k].rst, vt[k].fl, vt[k].req, vt[k].cm, vt[k].f0, vt[k].f1);
            if (!vt[k].rst)
                assert (int'(vt[k].cm[0]) + int'(vt[k].cm[1]) <= 32 - vt[k].cnt)
                    else $error("illegal stimulus: commit exceeds outstanding allocations at vector %0d", k);
            @(negedge clk);
            check_outs($sformatf("v%0d", k), vt[k].gnt, vt[k].i0, vt[k].i1, vt[k].cnt);
            @(posedge clk);
            #1;
        end

        // Flush with no commit: the single outstanding allocation is discarded and reissued.
        drive(1,0,2'b11,2'b00,0,0);
        @(negedge clk);
        check_outs("seq_rst", 2'b00, 0, 0, 0);
        @(posedge clk); #1;
        drive(0,0,2'b01,2'b00,0,0);
        @(negedge clk);
        check_outs("seq_alloc", 2'b01, 32, 0, 32);
        @(posedge clk); #1;
        drive(0,1,2'b11,2'b00,0,0);
        @(negedge clk);
        check_outs("seq_flush", 2'b00, 0, 0, 31);
        @(posedge clk); #1;
        drive(0,0,2'b11,2'b00,0,0);
        @(negedge clk);
        check_outs("seq_after", 2'b11, 32, 33, 32);
        @(posedge clk); #1;
        drive(0,0,2'b00,2'b00,0,0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
